ml_ahb_slave_port_arbiter: RTL and testbench

// Per-slave-port arbiter of the AHB multi-layer matrix. It sits directly upstream of the
// per-master path-selection FSMs and drives the 'grant' input of each FSM for this slave.
// It picks one address-phase owner among N masters using round-robin order.
// It holds ownership across bursts and locked sequences, and parks on the last owner when idle.
// It also tracks the data-phase owner that the slave response and read-data mux uses.

---
 rtl/ml_ahb_slave_port_arbiter.sv | 87 ++++++++
 tb/tb_ml_ahb_slave_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ml_ahb_slave_port_arbiter.sv
// Per-slave-port round-robin arbiter for the AHB multi-layer matrix.
// Registered one-hot address-phase grant, burst/lock hold, park-on-last, data-phase owner tracking.
module ml_ahb_slave_port_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   hclk,
    input  logic                   resetn,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] seq,
    input  logic [NUM_MASTERS-1:0] mastlock,
    input  logic                   hready_slave,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       owner_idx,
    output logic [NUM_MASTERS-1:0] data_grant,
    output logic                   data_valid,
    output logic [4:0]             hold_cnt
);

    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    logic                   locked;
    logic                   own_req;
    logic                   own_seq;
    logic                   own_lock;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       next_owner;
    logic [4:0]             next_hold;
    logic                   next_locked;
    logic [NUM_MASTERS-1:0] next_grant;

    assign own_req  = req[owner_idx];
    assign own_seq  = seq[owner_idx];
    assign own_lock = mastlock[owner_idx];

    // Scan from the farthest offset down so the nearest requester after the owner wins;
    // offset NUM_MASTERS is the owner itself, searched last.
    always_comb begin
        cand   = '0;
        rr_idx = owner_idx;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = IDX_W'((int'(owner_idx) + k) % NUM_MASTERS);
            if (req[cand]) rr_idx = cand;
        end
    end

    always_comb begin
        next_owner  = owner_idx;
        next_hold   = '0;
        next_locked = 1'b0;
        if (locked || (own_lock && own_req)) begin
            // The lock persists through IDLE gaps and clears only when HMASTLOCK drops.
            next_locked = own_lock;
        end else if (own_req && own_seq && (hold_cnt < HOLD_LAST)) begin
            next_hold = hold_cnt + 5'd1;
        end else if (|req) begin
            next_owner = rr_idx;
        end
    end

    always_comb begin
        next_grant             = '0;
        next_grant[next_owner] = 1'b1;
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            grant      <= NUM_MASTERS'(1);
            owner_idx  <= '0;
            data_grant <= '0;
            data_valid <= 1'b0;
            hold_cnt   <= '0;
            locked     <= 1'b0;
        end else if (hready_slave) begin
            grant      <= next_grant;
            owner_idx  <= next_owner;
            hold_cnt   <= next_hold;
            locked     <= next_locked;
            // Data phase is owned by whoever held the address phase before this edge.
            data_valid <= own_req;
            data_grant <= own_req ? grant : '0;
        end
    end

endmodule

// File: tb/tb_ml_ahb_slave_port_arbiter.sv
// Directed self-checking bench for ml_ahb_slave_port_arbiter (NUM_MASTERS=4, MAX_HOLD=16).
module tb_ml_ahb_slave_port_arbiter;

    logic       hclk = 1'b0;
    logic       resetn;
    logic [3:0] req, seq, mastlock;
    logic       hready_slave;
    logic [3:0] grant, data_grant;
    logic [1:0] owner_idx;
    logic       data_valid;
    logic [4:0] hold_cnt;

    int checks   = 0;
    int failures = 0;

    ml_ahb_slave_port_arbiter #(.NUM_MASTERS(4), .IDX_W(2), .MAX_HOLD(16)) dut (
        .hclk(hclk), .resetn(resetn), .req(req), .seq(seq), .mastlock(mastlock),
        .hready_slave(hready_slave), .grant(grant), .owner_idx(owner_idx),
        .data_grant(data_grant), .data_valid(data_valid), .hold_cnt(hold_cnt)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; req = '0; seq = '0; mastlock = '0; hready_slave = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_grant", 32'(grant), 32'h1);
        chk("rst_owner", 32'(owner_idx), 32'h0);
        chk("rst_dgrant", 32'(data_grant), 32'h0);
        chk("rst_dvalid", 32'(data_valid), 32'h0);
        chk("rst_hold", 32'(hold_cnt), 32'h0);
        resetn = 1'b1;

        // idle park on master 0
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_grant", 32'(grant), 32'h1);
            chk("idle_dvalid", 32'(data_valid), 32'h0);
        end

        // round robin among masters 1 and 2
        req = 4'b0110;
        step();
        chk("rr1_grant", 32'(grant), 32'h2);
        chk("rr1_owner", 32'(owner_idx), 32'h1);
        chk("rr1_dvalid", 32'(data_valid), 32'h0);
        step();
        chk("rr2_grant", 32'(grant), 32'h4);
        chk("rr2_dgrant", 32'(data_grant), 32'h2);
        step();
        chk("rr3_grant", 32'(grant), 32'h2);
        chk("rr3_dgrant", 32'(data_grant), 32'h4);

        // burst hold limit: owner 1 keeps 16 beats, then forced rotation
        req = 4'b1111; seq = 4'b1111;
        chk("hold_start", 32'(hold_cnt), 32'h0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("hold_grant", 32'(grant), 32'h2);
            chk("hold_cnt", 32'(hold_cnt), 32'(i));
        end
        step();
        chk("hold_rot_grant", 32'(grant), 32'h4);
        chk("hold_rot_cnt", 32'(hold_cnt), 32'h0);
        chk("hold_rot_dgrant", 32'(data_grant), 32'h2);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("hold2_grant", 32'(grant), 32'h4);
            chk("hold2_cnt", 32'(hold_cnt), 32'(i));
        end

        // park, then sole requester re-granted
        req = '0; seq = '0;
        step();
        chk("park_grant", 32'(grant), 32'h4);
        chk("park_hold", 32'(hold_cnt), 32'h0);
        chk("park_dvalid", 32'(data_valid), 32'h0);
        req = 4'b0100;
        step();
        chk("sole_grant", 32'(grant), 32'h4);
        chk("sole_dgrant", 32'(data_grant), 32'h4);
        chk("sole_dvalid", 32'(data_valid), 32'h1);

        // hready low freezes everything
        hready_slave = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = (i == 0) ? 4'b1000 : (i == 1) ? 4'b0001 : 4'b1001;
            step();
            chk("frz_grant", 32'(grant), 32'h4);
            chk("frz_owner", 32'(owner_idx), 32'h2);
            chk("frz_dgrant", 32'(data_grant), 32'h4);
            chk("frz_dvalid", 32'(data_valid), 32'h1);
        end
        hready_slave = 1'b1;
        step();
        chk("thaw_grant", 32'(grant), 32'h8);
        chk("thaw_owner", 32'(owner_idx), 32'h3);
        chk("thaw_dvalid", 32'(data_valid), 32'h0);

        // locked sequence with IDLE gaps keeps master 3
        mastlock = 4'b1000; req = 4'b1111;
        step();
        chk("lk1_grant", 32'(grant), 32'h8);
        req = 4'b0111;
        step();
        chk("lk_gap1", 32'(grant), 32'h8);
        step();
        chk("lk_gap2", 32'(grant), 32'h8);
        req = 4'b1111;
        step();
        chk("lk2_grant", 32'(grant), 32'h8);
        req = 4'b0111;
        step();
        chk("lk_gap3", 32'(grant), 32'h8);
        mastlock = '0;
        step();
        chk("lk_drop_grant", 32'(grant), 32'h8);
        step();
        chk("lk_wrap_grant", 32'(grant), 32'h1);
        chk("lk_wrap_owner", 32'(owner_idx), 32'h0);

        // reset mid-burst while master 2 owns
        req = 4'b0100; seq = 4'b0100;
        step();
        chk("pre_rst_grant", 32'(grant), 32'h4);
        step();
        chk("pre_rst_hold", 32'(hold_cnt), 32'h1);
        chk("pre_rst_dvalid", 32'(data_valid), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h1);
        chk("arst_owner", 32'(owner_idx), 32'h0);
        chk("arst_dvalid", 32'(data_valid), 32'h0);
        chk("arst_dgrant", 32'(data_grant), 32'h0);
        chk("arst_hold", 32'(hold_cnt), 32'h0);
        req = '0; seq = '0;
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_grant", 32'(grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
